// File: rtl/data_mem_pkg.sv
// Shared widths and constants for the data_mem word store.
package data_mem_pkg;

  localparam int unsigned DATA_W            = 16;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned STOR_SIZE_DEFAULT = 32768;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // True when n is a non-zero power of two; used to vet the depth parameter.
  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word storage: synchronous write, combinational read of the
// addressed word. Contents start at zero and are never cleared afterwards.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH = STOR_SIZE_DEFAULT,
  parameter int unsigned IDX_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: ZERO_WORD};

  // Store the write word on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory with a registered read port.
// The top level decodes the address range, chooses between the stored word
// and the incoming write word, and owns the rdData register, which clears
// asynchronously on rst while the storage array keeps its contents.
// Build option: define DATAMEM_BYPASS_EN to return wrData on a same-edge
// read/write of one in-range word (write-through); otherwise the old word
// is returned (read-before-write).
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned storSize = STOR_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] addr,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [DATA_W-1:0] rdData
);

  localparam int unsigned IDX_W = $clog2(storSize);

  if (!is_pow2(storSize) || storSize < 2 || storSize > 65536) begin : g_bad_size
    $error("data_mem: storSize must be a power of two in 2..65536");
  end

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              we;
  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] rd_next;

  // Addresses at or beyond the depth never reach the array, so no aliasing.
  assign in_range = (32'(addr) < storSize);
  assign idx      = addr[IDX_W-1:0];
  assign we       = memWrite && !rst && in_range;

  data_mem_array #(
    .DEPTH (storSize),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idx),
    .wdata (wrData),
    .rdata (ram_word)
  );

  // Select the word a read on this edge should return.
  always_comb begin
    rd_next = ZERO_WORD;
    if (in_range) begin
`ifdef DATAMEM_BYPASS_EN
      if (memWrite) begin
        rd_next = wrData;
      end else begin
        rd_next = ram_word;
      end
`else
      rd_next = ram_word;
`endif
    end
  end

  // Output register: cleared at once by rst, loaded only on enabled reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData <= ZERO_WORD;
    end else if (memRead) begin
      rdData <= rd_next;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem (default depth 32768). Each step pushes the
// rdData value expected after its clock edge into a scoreboard queue.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wrData;
  logic [15:0] addr;
  logic        memRead;
  logic        memWrite;
  logic [15:0] rdData;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  data_mem dut (
    .clk      (clk),
    .rst      (rst),
    .wrData   (wrData),
    .addr     (addr),
    .memRead  (memRead),
    .memWrite (memWrite),
    .rdData   (rdData)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Drive one request, queue the expected rdData, then compare after the edge.
  task automatic step(input string tag, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp);
    logic [15:0] e;
    string       t;
    memRead  = rd;
    memWrite = wr;
    addr     = a;
    wrData   = d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, rdData, e);
  endtask

  logic [15:0] byp_exp;

  initial begin
`ifdef DATAMEM_BYPASS_EN
    byp_exp = 16'h1234;
`else
    byp_exp = 16'h0000;
`endif
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = '0; wrData = '0;
    #1;
    check("reset_async", rdData, 16'h0000);
    step("reset_hold_read", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b0;
    step("read0_after_reset", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("write_baba_hold",   1'b0, 1'b1, 16'h0000, 16'hBABA, 16'h0000);
    step("read0_baba",        1'b1, 1'b0, 16'h0000, 16'h0000, 16'hBABA);
    step("write_1eaf_hold",   1'b0, 1'b1, 16'h0001, 16'h1EAF, 16'hBABA);
    step("read1_1eaf",        1'b1, 1'b0, 16'h0001, 16'h0000, 16'h1EAF);
    step("read0_intact",      1'b1, 1'b0, 16'h0000, 16'h0000, 16'hBABA);
    step("hold_during_write", 1'b0, 1'b1, 16'h0003, 16'hFFFF, 16'hBABA);
    step("hold_idle",         1'b0, 1'b0, 16'h0001, 16'h5A5A, 16'hBABA);
    step("write_oor_hold",    1'b0, 1'b1, 16'h8000, 16'hDEAD, 16'hBABA);
    step("read_oor_8000",     1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000);
    step("read0_no_alias",    1'b1, 1'b0, 16'h0000, 16'h0000, 16'hBABA);
    step("write_top_hold",    1'b0, 1'b1, 16'h7FFF, 16'h5555, 16'hBABA);
    step("read_top_7fff",     1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h5555);
    step("read_oor_ffff",     1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000);
    step("read_unwritten_5",  1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000);
    step("rw_same_addr2",     1'b1, 1'b1, 16'h0002, 16'h1234, byp_exp);
    step("read2_after_rw",    1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1234);
    step("read0_before_rst",  1'b1, 1'b0, 16'h0000, 16'h0000, 16'hBABA);
    // Reset raised between edges must clear rdData without a clock.
    #3;
    rst = 1'b1;
    #1;
    check("mid_cycle_reset", rdData, 16'h0000);
    step("rw_during_reset",   1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b0;
    step("read0_after_rst",   1'b1, 1'b0, 16'h0000, 16'h0000, 16'hBABA);
    step("read1_after_rst",   1'b1, 1'b0, 16'h0001, 16'h0000, 16'h1EAF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
